// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared constants for the video scanout block
package video_pkg;

    localparam int MODE_2BPP = 0;
    localparam int MODE_DBL  = 1;

    localparam logic [2:0] SEL_MODE   = 3'd0;
    localparam logic [2:0] SEL_BORDER = 3'd1;
    localparam logic [2:0] SEL_PAL0   = 3'd2;
    localparam logic [2:0] SEL_PAL1   = 3'd3;
    localparam logic [2:0] SEL_PAL2   = 3'd4;
    localparam logic [2:0] SEL_PAL3   = 3'd5;

    localparam logic [3:0] PAL_RST0 = 4'h0;
    localparam logic [3:0] PAL_RST1 = 4'h5;
    localparam logic [3:0] PAL_RST2 = 4'hA;
    localparam logic [3:0] PAL_RST3 = 4'hF;

    localparam int DEF_ADDR_W       = 17;
    localparam int DEF_H_ACTIVE     = 128;
    localparam int DEF_H_SYNC_START = 148;
    localparam int DEF_H_SYNC_END   = 172;
    localparam int DEF_H_TOTAL      = 201;
    localparam int DEF_V_ACTIVE     = 480;
    localparam int DEF_V_SYNC_START = 490;
    localparam int DEF_V_SYNC_END   = 492;
    localparam int DEF_V_TOTAL      = 525;
    localparam bit DEF_HSYNC_POL    = 1'b0;
    localparam bit DEF_VSYNC_POL    = 1'b0;

endpackage

// File: rtl/video_timing.sv
// rtl/video_timing.sv - byte/line counters, registered syncs and region flags
module video_timing
    import video_pkg::*;
#(
    parameter int H_ACTIVE     = DEF_H_ACTIVE,
    parameter int H_SYNC_START = DEF_H_SYNC_START,
    parameter int H_SYNC_END   = DEF_H_SYNC_END,
    parameter int H_TOTAL      = DEF_H_TOTAL,
    parameter int V_ACTIVE     = DEF_V_ACTIVE,
    parameter int V_SYNC_START = DEF_V_SYNC_START,
    parameter int V_SYNC_END   = DEF_V_SYNC_END,
    parameter int V_TOTAL      = DEF_V_TOTAL,
    parameter bit HSYNC_POL    = DEF_HSYNC_POL,
    parameter bit VSYNC_POL    = DEF_VSYNC_POL,
    parameter int HB_W         = $clog2(H_ACTIVE),
    parameter int VC_W         = $clog2(V_TOTAL)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_step,
    output logic [HB_W-1:0] o_hbyte,
    output logic [VC_W-1:0] o_vcount,
    output logic            o_hsync,
    output logic            o_vsync,
    output logic            o_active,
    output logic            o_border_win
);

    localparam int HC_W = $clog2(H_TOTAL);

    localparam logic [HC_W-1:0] H_ACT  = HC_W'(H_ACTIVE);
    localparam logic [HC_W-1:0] H_SS   = HC_W'(H_SYNC_START);
    localparam logic [HC_W-1:0] H_SE   = HC_W'(H_SYNC_END);
    localparam logic [HC_W-1:0] H_LAST = HC_W'(H_TOTAL - 1);
    localparam logic [VC_W-1:0] V_ACT  = VC_W'(V_ACTIVE);
    localparam logic [VC_W-1:0] V_SS   = VC_W'(V_SYNC_START);
    localparam logic [VC_W-1:0] V_SE   = VC_W'(V_SYNC_END);
    localparam logic [VC_W-1:0] V_LAST = VC_W'(V_TOTAL - 1);

    logic [HC_W-1:0] r_hcount;
    logic [VC_W-1:0] r_vcount;
    logic [HC_W-1:0] w_h_next;
    logic [VC_W-1:0] w_v_next;
    logic            r_hsync;
    logic            r_vsync;

    always_comb begin
        w_h_next = r_hcount + HC_W'(1);
        w_v_next = r_vcount;
        if (r_hcount == H_LAST) begin
            w_h_next = '0;
            w_v_next = (r_vcount == V_LAST) ? '0 : r_vcount + VC_W'(1);
        end
    end

    // Syncs are decoded from the next count so they line up with the new byte.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hcount <= '0;
            r_vcount <= '0;
            r_hsync  <= ~HSYNC_POL;
            r_vsync  <= ~VSYNC_POL;
        end else if (i_step) begin
            r_hcount <= w_h_next;
            r_vcount <= w_v_next;
            r_hsync  <= ((w_h_next >= H_SS) && (w_h_next < H_SE)) ? HSYNC_POL : ~HSYNC_POL;
            r_vsync  <= ((w_v_next >= V_SS) && (w_v_next < V_SE)) ? VSYNC_POL : ~VSYNC_POL;
        end
    end

    assign o_hbyte      = r_hcount[HB_W-1:0];
    assign o_vcount     = r_vcount;
    assign o_hsync      = r_hsync;
    assign o_vsync      = r_vsync;
    assign o_active     = (r_hcount < H_ACT) && (r_vcount < V_ACT);
    assign o_border_win = (r_hcount < H_SS) && (r_vcount < V_SS);

endmodule

// File: rtl/video_scanout.sv
// rtl/video_scanout.sv - bus slot phasing, fetch addressing and RGBI pixel serialiser
module video_scanout
    import video_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int H_ACTIVE     = DEF_H_ACTIVE,
    parameter int H_SYNC_START = DEF_H_SYNC_START,
    parameter int H_SYNC_END   = DEF_H_SYNC_END,
    parameter int H_TOTAL      = DEF_H_TOTAL,
    parameter int V_ACTIVE     = DEF_V_ACTIVE,
    parameter int V_SYNC_START = DEF_V_SYNC_START,
    parameter int V_SYNC_END   = DEF_V_SYNC_END,
    parameter int V_TOTAL      = DEF_V_TOTAL,
    parameter bit HSYNC_POL    = DEF_HSYNC_POL,
    parameter bit VSYNC_POL    = DEF_VSYNC_POL
) (
    input  logic              master_clock,
    input  logic              reset_n,
    output logic              phi2,
    output logic              half,
    output logic [ADDR_W-1:0] video_addr,
    output logic              fetch_latch,
    input  logic [7:0]        data_in,
    input  logic              cpu_wr,
    input  logic [2:0]        cpu_sel,
    input  logic [7:0]        cpu_data,
    output logic              hsync,
    output logic              vsync,
    output logic [3:0]        rgbi,
    output logic              de
);

    localparam int HB_W = $clog2(H_ACTIVE);
    localparam int VC_W = $clog2(V_TOTAL);

    logic [1:0]           r_phase;
    logic [1:0]           r_mode;
    logic [3:0]           r_border;
    logic [3:0]           r_pal [4];
    logic [3:0]           r_pix [4];
    logic                 r_slot_active;
    logic [3:0]           r_slot_color;
    logic [3:0]           r_rgbi;
    logic                 r_de;

    logic [HB_W-1:0]      w_hbyte;
    logic [VC_W-1:0]      w_vcount;
    logic [VC_W-1:0]      w_row;
    logic [VC_W+HB_W-1:0] w_addr_full;
    logic                 w_active;
    logic                 w_border_win;
    logic                 w_step;
    logic                 w_capture;
    logic [3:0]           w_new_pix [4];
    logic                 w_unused_data;

    assign w_step    = (r_phase == 2'd3);
    assign w_capture = (r_phase == 2'd1);

    video_timing #(
        .H_ACTIVE    (H_ACTIVE),
        .H_SYNC_START(H_SYNC_START),
        .H_SYNC_END  (H_SYNC_END),
        .H_TOTAL     (H_TOTAL),
        .V_ACTIVE    (V_ACTIVE),
        .V_SYNC_START(V_SYNC_START),
        .V_SYNC_END  (V_SYNC_END),
        .V_TOTAL     (V_TOTAL),
        .HSYNC_POL   (HSYNC_POL),
        .VSYNC_POL   (VSYNC_POL),
        .HB_W        (HB_W),
        .VC_W        (VC_W)
    ) u_timing (
        .i_clk       (master_clock),
        .i_rst_n     (reset_n),
        .i_step      (w_step),
        .o_hbyte     (w_hbyte),
        .o_vcount    (w_vcount),
        .o_hsync     (hsync),
        .o_vsync     (vsync),
        .o_active    (w_active),
        .o_border_win(w_border_win)
    );

    assign w_row       = r_mode[MODE_DBL] ? (w_vcount >> 1) : w_vcount;
    assign w_addr_full = {w_row, w_hbyte};
    assign video_addr  = ADDR_W'(w_addr_full);

    // Palette lookup happens at capture, so later palette writes never touch a byte in flight.
    always_comb begin
        if (r_mode[MODE_2BPP]) begin
            w_new_pix[0] = r_pal[data_in[7:6]];
            w_new_pix[1] = r_pal[data_in[5:4]];
            w_new_pix[2] = r_pal[data_in[3:2]];
            w_new_pix[3] = r_pal[data_in[1:0]];
        end else begin
            w_new_pix[0] = data_in[7:4];
            w_new_pix[1] = data_in[7:4];
            w_new_pix[2] = data_in[3:0];
            w_new_pix[3] = data_in[3:0];
        end
    end

    always_ff @(posedge master_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_phase  <= 2'd0;
            r_mode   <= 2'd0;
            r_border <= 4'h0;
            r_pal[0] <= PAL_RST0;
            r_pal[1] <= PAL_RST1;
            r_pal[2] <= PAL_RST2;
            r_pal[3] <= PAL_RST3;
            for (int i = 0; i < 4; i++) r_pix[i] <= 4'h0;
            r_slot_active <= 1'b0;
            r_slot_color  <= 4'h0;
            r_rgbi        <= 4'h0;
            r_de          <= 1'b0;
        end else begin
            r_phase <= r_phase + 2'd1;
            if (w_step && cpu_wr) begin
                case (cpu_sel)
                    SEL_MODE:   r_mode   <= cpu_data[1:0];
                    SEL_BORDER: r_border <= cpu_data[3:0];
                    SEL_PAL0:   r_pal[0] <= cpu_data[3:0];
                    SEL_PAL1:   r_pal[1] <= cpu_data[3:0];
                    SEL_PAL2:   r_pal[2] <= cpu_data[3:0];
                    SEL_PAL3:   r_pal[3] <= cpu_data[3:0];
                    default: ;
                endcase
            end
            // First pixel bypasses the shifter so it shows in phase 2 of the same slot.
            if (w_capture) begin
                r_pix         <= w_new_pix;
                r_slot_active <= w_active;
                r_slot_color  <= w_border_win ? r_border : 4'h0;
                r_de          <= w_active;
                r_rgbi        <= w_active ? w_new_pix[0] : (w_border_win ? r_border : 4'h0);
            end else begin
                r_de   <= r_slot_active;
                r_rgbi <= r_slot_active ? r_pix[r_phase - 2'd1] : r_slot_color;
            end
        end
    end

    assign phi2          = r_phase[1];
    assign half          = r_phase[0];
    assign fetch_latch   = w_capture;
    assign rgbi          = r_rgbi;
    assign de            = r_de;
    assign w_unused_data = ^cpu_data[7:4];

endmodule
